cla_mult_seq: RTL and testbench

//  Sequential shift-add unsigned multiplier for the simple ALU. Sequences one
//  16-bit carry-lookahead adder over WIDTH cycles to form a 2*WIDTH-bit product.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/CLA_16bit.sv | 35 +++
 rtl/cla_mult_seq.sv | 101 ++++++++++
 tb/tb_cla_mult_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the simple ALU: multiplier FSM state encoding,
// adder width and carry-lookahead helper functions.
package alu_pkg;

    localparam int ADD_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Carries into bits 0..3 of a 4-bit lookahead block, each in two-level form.
    function automatic logic [3:0] carries4(input logic [3:0] g,
                                            input logic [3:0] p,
                                            input logic       ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    // Block generate of a 4-bit group; bit 0 propagate never matters here.
    function automatic logic grp_gen(input logic [3:0] g,
                                     input logic [3:1] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

// File: rtl/CLA_16bit.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups with a group
// lookahead stage. Purely combinational.
module CLA_16bit
    import alu_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    output logic [ADD_W-1:0] sum,
    output logic             cout
);

    logic [ADD_W-1:0] g;
    logic [ADD_W-1:0] p;
    logic [ADD_W-1:0] c;
    logic [3:0]       gg;
    logic [3:0]       gp;
    logic [3:0]       gc;

    // NOTE: continuous assigns keep the adder free of stored state, so no latch can creep in.
    assign g = a & b;
    assign p = a ^ b;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        assign gg[k]        = grp_gen(g[4*k +: 4], p[4*k+1 +: 3]);
        assign gp[k]        = &p[4*k +: 4];
        assign c[4*k +: 4]  = carries4(g[4*k +: 4], p[4*k +: 4], gc[k]);
    end

    // Second level: carries into each group straight from group G/P and cin.
    assign gc   = carries4(gg, gp, cin);
    assign cout = grp_gen(gg, gp[3:1]) | (&gp & cin);
    assign sum  = p ^ c;

endmodule

// File: rtl/cla_mult_seq.sv
// Sequential shift-add unsigned multiplier. One CLA_16bit adder is reused
// over WIDTH cycles (one multiplier bit per cycle) to build the product.
// Optional build macro: EARLY_EXIT_EN -- finish as soon as the remaining
// multiplier bits are all zero instead of always running WIDTH steps.
module cla_mult_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [ADD_W-1:0] product_o
);

    state_t           state;
    logic [ADD_W-1:0] mcand_sh;
    logic [ADD_W-1:0] acc;
    logic [WIDTH-1:0] mplr;
    logic [CNT_W-1:0] cnt;

    logic [ADD_W-1:0] addend;
    logic [ADD_W-1:0] sum;
    logic             adder_cout;
    logic             unused_cout;
    logic             last_step;

    assign addend = mplr[0] ? mcand_sh : '0;

    CLA_16bit u_adder (
        .a    (acc),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (adder_cout)
    );

    // Carry-out cannot be set for legal WIDTH; kept as a named net for observation.
    assign unused_cout = adder_cout;

`ifdef EARLY_EXIT_EN
    assign last_step = (cnt == CNT_W'(WIDTH - 1)) || ((mplr >> 1) == '0);
`else
    assign last_step = (cnt == CNT_W'(WIDTH - 1));
`endif

    // Control FSM plus datapath registers; outputs are registered here.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mcand_sh  <= '0;
            acc       <= '0;
            mplr      <= '0;
            cnt       <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            product_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        mcand_sh <= ADD_W'(a_i);
                        mplr     <= b_i;
                        acc      <= '0;
                        cnt      <= '0;
                        busy_o   <= 1'b1;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc      <= sum;
                    mcand_sh <= mcand_sh << 1;
                    mplr     <= mplr >> 1;
                    cnt      <= cnt + CNT_W'(1);
                    if (last_step) begin
                        product_o <= sum;
                        done_o    <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_mult_seq.sv
// Directed self-checking bench for cla_mult_seq (WIDTH=8). Inputs change and
// outputs are sampled on the falling edge, away from the active rising edge.
module tb_cla_mult_seq;

    localparam int WIDTH = 8;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [7:0]  a_i;
    logic [7:0]  b_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] product_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit cout_seen = 0;

    cla_mult_seq #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .product_o (product_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sticky record of any adder carry-out while out of reset.
    always @(negedge clk) begin
        if (!rst && dut.adder_cout === 1'b1) cout_seen = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected cycles from accepting edge to done_o.
    function automatic int lat_of(input logic [7:0] b);
`ifdef EARLY_EXIT_EN
        int l = 1;
        for (int i = 0; i < 8; i++) if (b[i]) l = i + 1;
        return l;
`else
        return (b === 8'hxx) ? 0 : WIDTH;
`endif
    endfunction

    // One multiply: optional extra start pulse during CALC (edge number
    // `inject`) and optional start pulse while in DONE; both must be ignored.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p,
                          input int inject, input bit poke_done);
        int lat;
        int busy_n;
        bit seen;
        @(negedge clk);
        a_i = a; b_i = b; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; a_i = 8'hEE; b_i = 8'hEE;
        busy_n = busy_o ? 1 : 0;
        seen = 1'b0;
        lat = 0;
        for (int e = 1; e <= 2 * WIDTH + 4 && !seen; e++) begin
            if (e == inject) begin
                start_i = 1'b1; a_i = 8'd9; b_i = 8'd9;
            end
            @(negedge clk);
            start_i = 1'b0;
            if (busy_o) busy_n++;
            if (done_o) begin
                seen = 1'b1;
                lat = e;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", lat, lat_of(b));
        check("product", 32'(product_o), 32'(exp_p));
        check("busy_len", busy_n, lat_of(b) + 1);
        if (poke_done) begin
            start_i = 1'b1; a_i = 8'd9; b_i = 8'd9;
        end
        @(negedge clk);
        start_i = 1'b0;
        check("done_pulse", 32'(done_o), 32'd0);
        check("back_idle", 32'(busy_o), 32'd0);
        check("held", 32'(product_o), 32'(exp_p));
    endtask

    initial begin
        int done_n;
        bit seen;
        rst = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_product", 32'(product_o), 32'd0);
        rst = 1'b0;

        // Basic operation and full-scale operands.
        run_op(8'h0D, 8'h0B, 16'h008F, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 16'hFE01, 0, 1'b0);
        check("cout_after_max", 32'(cout_seen), 32'd0);

        // Zero operands.
        run_op(8'h00, 8'hA5, 16'h0000, 0, 1'b0);
        run_op(8'h5A, 8'h00, 16'h0000, 0, 1'b0);

        // Start requests while busy (CALC and DONE) are ignored.
        run_op(8'h03, 8'h04, 16'h000C, 2, 1'b1);

        // start_i held high: restart on the first IDLE cycle after DONE.
        @(negedge clk);
        a_i = 8'd2; b_i = 8'd3; start_i = 1'b1;
        seen = 1'b0;
        for (int e = 0; e <= 2 * WIDTH + 4 && !seen; e++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        check("held_first_done", 32'(seen), 32'd1);
        check("held_first_prod", 32'(product_o), 32'h0006);
        @(negedge clk);
        check("held_gap_idle", 32'(busy_o), 32'd0);
        a_i = 8'd5; b_i = 8'd5;
        @(negedge clk);
        check("held_restart", 32'(busy_o), 32'd1);
        start_i = 1'b0;
        seen = 1'b0;
        for (int e = 0; e <= 2 * WIDTH + 4 && !seen; e++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        check("held_second_done", 32'(seen), 32'd1);
        check("held_second_prod", 32'(product_o), 32'h0019);
        @(negedge clk);

        // Reset in the fourth CALC cycle: immediate clear, no done pulse.
        @(negedge clk);
        a_i = 8'h0D; b_i = 8'h0B; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        check("abort_product", 32'(product_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_n = 0;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            if (done_o) done_n++;
        end
        check("abort_no_done", done_n, 0);
        run_op(8'h0D, 8'h0B, 16'h008F, 0, 1'b0);

        // Latency extremes of the multiplier (early exit when enabled).
        run_op(8'h07, 8'h01, 16'h0007, 0, 1'b0);
        run_op(8'h07, 8'h80, 16'h0380, 0, 1'b0);

        check("cout_never", 32'(cout_seen), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
